// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op/state encodings and width defaults for muldiv_unit
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int c_length       = 32;
    localparam int c_op_length    = 3;
    localparam int c_count_length = 6;

    typedef enum logic [c_op_length-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
// muldiv_if : request/result bundle between execute stage and muldiv_unit
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface muldiv_if #(
    parameter int LENGTH    = 32,
    parameter int OP_LENGTH = 3
);
    logic                 start;
    logic [OP_LENGTH-1:0] op;
    logic [LENGTH-1:0]    a;
    logic [LENGTH-1:0]    b;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [LENGTH-1:0]    hi;
    logic [LENGTH-1:0]    lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step : one radix-2 iteration, shift-add multiply or restoring divide
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int LENGTH = 32
) (
    input  wire logic                  is_div,
    input  wire logic [2*LENGTH-1:0]   acc,
    input  wire logic [LENGTH-1:0]     operand,
    output logic      [2*LENGTH-1:0]   acc_next
);

    logic [LENGTH:0] w_sum;
    logic [LENGTH:0] w_rem_shift;
    logic [LENGTH:0] w_diff;

    // Multiply: upper half accumulates, multiplier bits drain out of the lower half.
    // Divide:   acc = {remainder, dividend/quotient}; quotient bits enter at bit 0.
    always_comb begin
        w_sum       = {1'b0, acc[2*LENGTH-1:LENGTH]} + (acc[0] ? {1'b0, operand} : '0);
        w_rem_shift = acc[2*LENGTH-1:LENGTH-1];
        w_diff      = w_rem_shift - {1'b0, operand};
        acc_next    = {w_sum, acc[LENGTH-1:1]};
        if (is_div) begin
            if (!w_diff[LENGTH]) begin
                acc_next = {w_diff[LENGTH-1:0], acc[LENGTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*LENGTH-2:0], 1'b0};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative MIPS HI/LO multiply/divide unit with mthi/mtlo
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int LENGTH       = c_length,
    parameter int OP_LENGTH    = c_op_length,
    parameter int COUNT_LENGTH = c_count_length
) (
    input wire logic  clk,
    input wire logic  rst,
    muldiv_if.slave   bus
);

    localparam logic [COUNT_LENGTH-1:0] c_last_step = COUNT_LENGTH'(LENGTH - 1);

    state_e                   r_state;
    state_e                   w_state_next;
    op_e                      w_op;
    logic [2*LENGTH-1:0]      r_acc;
    logic [2*LENGTH-1:0]      w_acc_step;
    logic [2*LENGTH-1:0]      w_prod_fix;
    logic [LENGTH-1:0]        r_operand;
    logic [LENGTH-1:0]        r_hi;
    logic [LENGTH-1:0]        r_lo;
    logic [LENGTH-1:0]        w_a_mag;
    logic [LENGTH-1:0]        w_b_mag;
    logic [LENGTH-1:0]        w_fix_hi;
    logic [LENGTH-1:0]        w_fix_lo;
    logic [COUNT_LENGTH-1:0]  r_count;
    logic                     r_is_div;
    logic                     r_neg_lo;
    logic                     r_neg_hi;
    logic                     r_done;
    logic                     r_dbz;
    logic                     w_launch;
    logic                     w_dbz_req;
    logic                     w_wr_hi;
    logic                     w_wr_lo;
    logic                     w_fix_done;
    logic                     w_op_signed;
    logic                     w_op_div;
    logic                     w_a_neg;
    logic                     w_b_neg;

    assign w_op        = op_e'(bus.op);
    assign w_op_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_op_div    = (w_op == OP_DIV)  || (w_op == OP_DIVU);
    assign w_a_neg     = w_op_signed & bus.a[LENGTH-1];
    assign w_b_neg     = w_op_signed & bus.b[LENGTH-1];
    // -2^(LENGTH-1) stays as-is and is read as its unsigned magnitude
    assign w_a_mag     = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag     = w_b_neg ? -bus.b : bus.b;

    muldiv_step #(
        .LENGTH (LENGTH)
    ) u_step (
        .is_div   (r_is_div),
        .acc      (r_acc),
        .operand  (r_operand),
        .acc_next (w_acc_step)
    );

    // Multiply negates the full product; divide negates quotient and remainder separately.
    always_comb begin
        w_prod_fix = r_neg_lo ? -r_acc : r_acc;
        w_fix_hi   = w_prod_fix[2*LENGTH-1:LENGTH];
        w_fix_lo   = w_prod_fix[LENGTH-1:0];
        if (r_is_div) begin
            w_fix_lo = r_neg_lo ? -r_acc[LENGTH-1:0] : r_acc[LENGTH-1:0];
            w_fix_hi = r_neg_hi ? -r_acc[2*LENGTH-1:LENGTH] : r_acc[2*LENGTH-1:LENGTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_dbz_req    = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        w_fix_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    case (w_op)
                        OP_MULT, OP_MULTU: begin
                            w_launch     = 1'b1;
                            w_state_next = CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.b == '0) begin
                                w_dbz_req = 1'b1;
                            end else begin
                                w_launch     = 1'b1;
                                w_state_next = CALC;
                            end
                        end
                        OP_MTHI: w_wr_hi = 1'b1;
                        OP_MTLO: w_wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (r_count == c_last_step) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_fix_done   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_operand <= '0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= w_fix_done | w_dbz_req;
            r_dbz  <= w_dbz_req;
            if (w_launch) begin
                r_acc     <= {{LENGTH{1'b0}}, w_a_mag};
                r_operand <= w_b_mag;
                r_count   <= '0;
                r_is_div  <= w_op_div;
                r_neg_lo  <= w_a_neg ^ w_b_neg;
                r_neg_hi  <= w_op_div ? w_a_neg : (w_a_neg ^ w_b_neg);
            end else if (r_state == CALC) begin
                r_acc   <= w_acc_step;
                r_count <= r_count + 1'b1;
            end
            if (r_state == FIX) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end else begin
                if (w_wr_hi) r_hi <= bus.a;
                if (w_wr_lo) r_lo <= bus.a;
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed vectors, arithmetic reference model and per-cycle compare
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    muldiv_if #(.LENGTH(32), .OP_LENGTH(3)) mif ();

    muldiv_unit #(
        .LENGTH       (32),
        .OP_LENGTH    (3),
        .COUNT_LENGTH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result arithmetic from plain integer ops, timing as a countdown
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dbz;
    int          m_left;
    longint      sa, sb, sq, sr;
    logic [63:0] uprod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_done = 0; m_dbz = 0;
        end else begin
            m_done = 0;
            m_dbz  = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1;
                end
            end else if (mif.start) begin
                sa = longint'($signed(mif.a));
                sb = longint'($signed(mif.b));
                case (mif.op)
                    3'd0: begin
                        sq = sa * sb;
                        uprod = 64'(sq);
                        p_hi = uprod[63:32]; p_lo = uprod[31:0]; m_left = 33;
                    end
                    3'd1: begin
                        uprod = {32'b0, mif.a} * {32'b0, mif.b};
                        p_hi = uprod[63:32]; p_lo = uprod[31:0]; m_left = 33;
                    end
                    3'd2, 3'd3: begin
                        if (mif.b == 0) begin
                            m_done = 1; m_dbz = 1;
                        end else if (mif.op == 3'd2) begin
                            sq = sa / sb; sr = sa % sb;
                            p_lo = sq[31:0]; p_hi = sr[31:0]; m_left = 33;
                        end else begin
                            p_lo = mif.a / mif.b; p_hi = mif.a % mif.b; m_left = 33;
                        end
                    end
                    3'd4: m_hi = mif.a;
                    3'd5: m_lo = mif.a;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_busy", 64'(mif.busy), 64'(m_left > 0));
            check("cyc_done", 64'(mif.done), 64'(m_done));
            check("cyc_dbz",  64'(mif.div_by_zero), 64'(m_dbz));
            check("cyc_hi",   64'(mif.hi), 64'(m_hi));
            check("cyc_lo",   64'(mif.lo), 64'(m_lo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        tick();
        mif.start = 1'b1; mif.op = o; mif.a = x; mif.b = y;
        tick();
        mif.start = 1'b0;
    endtask

    // Returns in the negedge of the cycle where done is high
    task automatic wait_done(input string name, output int busy_cycles);
        bit seen;
        seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mif.busy) busy_cycles++;
            if (mif.done) begin
                seen = 1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
        check({name, "_hi"}, 64'(mif.hi), 64'(h));
        check({name, "_lo"}, 64'(mif.lo), 64'(l));
    endtask

    int  bc;
    bit  late_done;

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1;
        mif.start = 1'b0; mif.op = 3'd0; mif.a = 32'd0; mif.b = 32'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(mif.busy), 64'd0);
        check("rst_done", 64'(mif.done), 64'd0);
        expect_hilo("rst", 32'h0, 32'h0);

        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", bc);
        check("mult_neg_busy_cycles", 64'(bc), 64'd33);
        expect_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(negedge clk);
        check("mult_neg_done_once", 64'(mif.done), 64'd0);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", bc);
        expect_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mult_m1", bc);
        expect_hilo("mult_m1", 32'h0, 32'h1);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", bc);
        expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd3, 32'd100, 32'd7);
        wait_done("divu", bc);
        expect_hilo("divu", 32'd2, 32'd14);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", bc);
        expect_hilo("div_ovf", 32'h0, 32'h8000_0000);

        issue(3'd4, 32'h1234, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        issue(3'd2, 32'd55, 32'd0);
        @(negedge clk);
        check("dbz_done", 64'(mif.done), 64'd1);
        check("dbz_flag", 64'(mif.div_by_zero), 64'd1);
        check("dbz_busy", 64'(mif.busy), 64'd0);
        repeat (2) @(negedge clk);
        expect_hilo("dbz_keep", 32'h1234, 32'h5678);

        // MTLO while busy must be dropped
        issue(3'd0, 32'd5, 32'd6);
        repeat (9) tick();
        mif.start = 1'b1; mif.op = 3'd5; mif.a = 32'hAAAA;
        tick();
        mif.start = 1'b0;
        wait_done("mtlo_busy", bc);
        expect_hilo("mtlo_busy", 32'h0, 32'd30);

        // New start presented in the done cycle
        issue(3'd0, 32'd3, 32'd4);
        wait_done("b2b_first", bc);
        mif.start = 1'b1; mif.op = 3'd3; mif.a = 32'd100; mif.b = 32'd7;
        tick();
        mif.start = 1'b0;
        wait_done("b2b_second", bc);
        check("b2b_busy_cycles", 64'(bc), 64'd33);
        expect_hilo("b2b_second", 32'd2, 32'd14);

        issue(3'd2, 32'hFFFF_FF9C, 32'd7);
        repeat (14) tick();
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 64'(mif.busy), 64'd0);
        check("arst_done", 64'(mif.done), 64'd0);
        expect_hilo("arst", 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        late_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.done) late_done = 1;
        end
        check("arst_no_done", 64'(late_done), 64'd0);

        issue(3'd3, 32'd9, 32'd3);
        wait_done("divu_after_rst", bc);
        expect_hilo("divu_after_rst", 32'd0, 32'd3);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
